// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Pipeline register file with a per-register busy scoreboard.
//   - Two combinational read ports and one write-back port.
//   - x0 is hardwired to zero and is never busy.
//   - Optional write-through bypass forwards a same-cycle write-back to the read ports.
//   - Busy bits are set at issue, cleared at write-back, and bulk-cleared on flush.
//   - The asynchronous reset clears both the data and the busy state.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   rs1/rs2 -> readdata1/2  read addresses and read data
//   rd, writedata, regwrite write-back port
//   rd_issue, issue       marks the issued instruction's destination busy
//   flush                 clears every busy bit
//   busy1/busy2, hazard   effective busy status of rs1/rs2, and their OR
//   busy_count            number of busy registers (registered state only)

// One architectural register together with its busy bit.
module regfile_scoreboard_cell #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [XLEN-1:0] wdata,
    input  logic            set,
    input  logic            flush,
    output logic [XLEN-1:0] q,
    output logic            busy
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q    <= '0;
            busy <= 1'b0;
        end else begin
            // The data write happens even during a flush.
            if (we) q <= wdata;
            // Priority is flush, then issue, then write-back.
            // Issue wins over write-back because the new producer is still outstanding.
            if (flush)    busy <= 1'b0;
            else if (set) busy <= 1'b1;
            else if (we)  busy <= 1'b0;
        end
    end
endmodule

module regfile_scoreboard #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] readdata1,
    output logic [XLEN-1:0] readdata2,
    input  logic [AW-1:0]   rd,
    input  logic [XLEN-1:0] writedata,
    input  logic            regwrite,
    input  logic [AW-1:0]   rd_issue,
    input  logic            issue,
    input  logic            flush,
    output logic            busy1,
    output logic            busy2,
    output logic            hazard,
    output logic [AW:0]     busy_count
);
    logic [NREGS-1:0][XLEN-1:0] regs;
    logic [NREGS-1:0]           busy;

    // Entry 0 is tied off; entries 1..NREGS-1 are real cells.
    assign regs[0] = '0;
    assign busy[0] = 1'b0;

    for (genvar i = 1; i < NREGS; i++) begin : g_cell
        localparam logic [AW-1:0] IDX = AW'(i);
        regfile_scoreboard_cell #(.XLEN(XLEN)) u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (regwrite && (rd == IDX)),
            .wdata (writedata),
            .set   (issue && (rd_issue == IDX)),
            .flush (flush),
            .q     (regs[i]),
            .busy  (busy[i])
        );
    end

    // Forwarding applies only to a nonzero address that matches the live write-back.
    logic fwd1, fwd2;
    assign fwd1 = (BYPASS != 0) && regwrite && (rd == rs1) && (rs1 != '0);
    assign fwd2 = (BYPASS != 0) && regwrite && (rd == rs2) && (rs2 != '0);

    // regs[0] is already zero, so an rsN of 0 needs no special case on the read path.
    assign readdata1 = fwd1 ? writedata : regs[rs1];
    assign readdata2 = fwd2 ? writedata : regs[rs2];

    // A forwarded operand is available this cycle, so it no longer counts as busy.
    assign busy1  = busy[rs1] && !fwd1;
    assign busy2  = busy[rs2] && !fwd2;
    assign hazard = busy1 | busy2;

    always_comb begin
        busy_count = '0;
        for (int i = 0; i < NREGS; i++) busy_count = busy_count + (AW+1)'(busy[i]);
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [AW-1:0]   rs1, rs2, rd, rd_issue;
    logic [XLEN-1:0] writedata;
    logic            regwrite, issue, flush;

    // Bypassing instance outputs
    logic [XLEN-1:0] rd1_b, rd2_b;
    logic            busy1_b, busy2_b, haz_b;
    logic [AW:0]     cnt_b;
    // Non-bypassing instance outputs
    logic [XLEN-1:0] rd1_n, rd2_n;
    logic            busy1_n, busy2_n, haz_n;
    logic [AW:0]     cnt_n;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2),
        .readdata1(rd1_b), .readdata2(rd2_b),
        .rd(rd), .writedata(writedata), .regwrite(regwrite),
        .rd_issue(rd_issue), .issue(issue), .flush(flush),
        .busy1(busy1_b), .busy2(busy2_b), .hazard(haz_b), .busy_count(cnt_b)
    );

    regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(0)) dut_n (
        .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2),
        .readdata1(rd1_n), .readdata2(rd2_n),
        .rd(rd), .writedata(writedata), .regwrite(regwrite),
        .rd_issue(rd_issue), .issue(issue), .flush(flush),
        .busy1(busy1_n), .busy2(busy2_n), .hazard(haz_n), .busy_count(cnt_n)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [XLEN-1:0] mreg  [NREGS];
    bit              mbusy [NREGS];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            foreach (mreg[i]) begin mreg[i] = '0; mbusy[i] = 0; end
        end else begin
            if (regwrite && rd != 0) mreg[rd] = writedata;
            if (flush) begin
                foreach (mbusy[i]) mbusy[i] = 0;
            end else begin
                if (regwrite && rd != 0)    mbusy[rd] = 0;
                if (issue && rd_issue != 0) mbusy[rd_issue] = 1;   // later assignment: issue wins
            end
        end
    end

    function automatic bit fwd(input logic [AW-1:0] a, input bit byp);
        return byp && regwrite && rd == a && a != 0;
    endfunction

    function automatic logic [XLEN-1:0] m_read(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return '0;
        if (fwd(a, byp)) return writedata;
        return mreg[a];
    endfunction

    function automatic bit m_busy(input logic [AW-1:0] a, input bit byp);
        return mbusy[a] && !fwd(a, byp);
    endfunction

    function automatic int m_count();
        int c = 0;
        foreach (mbusy[i]) c += int'(mbusy[i]);
        return c;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        chk("rd1_b",  rd1_b,   m_read(rs1, 1));
        chk("rd2_b",  rd2_b,   m_read(rs2, 1));
        chk("busy1_b", 32'(busy1_b), 32'(m_busy(rs1, 1)));
        chk("busy2_b", 32'(busy2_b), 32'(m_busy(rs2, 1)));
        chk("haz_b",  32'(haz_b), 32'(m_busy(rs1, 1) | m_busy(rs2, 1)));
        chk("cnt_b",  32'(cnt_b), 32'(m_count()));
        chk("rd1_n",  rd1_n,   m_read(rs1, 0));
        chk("rd2_n",  rd2_n,   m_read(rs2, 0));
        chk("busy1_n", 32'(busy1_n), 32'(m_busy(rs1, 0)));
        chk("busy2_n", 32'(busy2_n), 32'(m_busy(rs2, 0)));
        chk("haz_n",  32'(haz_n), 32'(m_busy(rs1, 0) | m_busy(rs2, 0)));
        chk("cnt_n",  32'(cnt_n), 32'(m_count()));
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        regwrite = 0; issue = 0; flush = 0;
        rd = '0; rd_issue = '0; writedata = '0;
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 0; rs1 = '0; rs2 = '0; idle();
        #2;
        chk("reset_rd1", rd1_b, 32'h0);
        chk("reset_cnt", 32'(cnt_b), 32'h0);
        step(); rst_n = 1;

        // Fill x1..x5, then an async reset pulse in the middle of a cycle.
        for (int i = 1; i <= 5; i++) begin
            regwrite = 1; rd = AW'(i); writedata = 32'(i); step();
        end
        idle(); rs1 = 5'd1; rs2 = 5'd5; #1;
        chk("pre_rst_rd1", rd1_b, 32'd1);
        chk("pre_rst_rd2", rd2_b, 32'd5);
        #1 rst_n = 0; #1;
        chk("mid_rst_rd1", rd1_b, 32'd0);
        chk("mid_rst_rd2", rd2_b, 32'd0);
        chk("mid_rst_cnt", 32'(cnt_b), 32'd0);
        rst_n = 1;

        // x0 is hardwired
        step(); regwrite = 1; rd = '0; writedata = 32'hDEADBEEF; issue = 1; rd_issue = '0;
        step(); idle(); rs1 = '0; #1;
        chk("x0_rd1", rd1_b, 32'd0);
        chk("x0_busy1", 32'(busy1_b), 32'd0);
        chk("x0_cnt", 32'(cnt_b), 32'd0);

        // write/read and bypass
        regwrite = 1; rd = 5'd2; writedata = 32'd2; step();
        rd = 5'd3; writedata = 32'd3; step();
        idle(); rs1 = 5'd2; rs2 = 5'd3; #1;
        chk("wr_rd1", rd1_b, 32'd2);
        chk("wr_rd2", rd2_b, 32'd3);
        regwrite = 1; rd = 5'd3; writedata = 32'd7; #1;
        chk("byp_rd2", rd2_b, 32'd7);
        chk("nobyp_rd2", rd2_n, 32'd3);
        step(); regwrite = 0; writedata = 32'd6; #1;
        chk("hold_rd2", rd2_b, 32'd7);
        chk("hold_rd2_n", rd2_n, 32'd7);

        // scoreboard set / write-back clear
        idle(); issue = 1; rd_issue = 5'd4; step();
        idle(); rs1 = 5'd4; rs2 = '0; #1;
        chk("sb_busy1", 32'(busy1_b), 32'd1);
        chk("sb_haz", 32'(haz_b), 32'd1);
        chk("sb_cnt", 32'(cnt_b), 32'd1);
        regwrite = 1; rd = 5'd4; writedata = 32'd9; #1;
        chk("wb_busy1_b", 32'(busy1_b), 32'd0);
        chk("wb_rd1_b", rd1_b, 32'd9);
        chk("wb_busy1_n", 32'(busy1_n), 32'd1);
        chk("wb_rd1_n", rd1_n, 32'd0);
        step(); idle(); #1;
        chk("wb_cnt", 32'(cnt_b), 32'd0);

        // simultaneous set and clear
        issue = 1; rd_issue = 5'd5; step();
        regwrite = 1; rd = 5'd5; writedata = 32'h55; step();
        idle(); rs1 = 5'd5; #1;
        chk("setclr_busy", 32'(busy1_n), 32'd1);
        chk("setclr_data", rd1_b, 32'h55);

        // flush
        flush = 1; step(); idle();
        for (int i = 1; i <= 3; i++) begin
            issue = 1; rd_issue = AW'(i); step();
        end
        idle(); #1;
        chk("fl_cnt3", 32'(cnt_b), 32'd3);
        flush = 1; issue = 1; rd_issue = 5'd6; regwrite = 1; rd = 5'd7; writedata = 32'h11;
        step(); idle(); rs1 = 5'd7; rs2 = 5'd6; #1;
        chk("fl_cnt0", 32'(cnt_b), 32'd0);
        chk("fl_x7", rd1_b, 32'h11);
        chk("fl_busy2", 32'(busy2_b), 32'd0);

        // randomized traffic; narrow address ranges make hazards frequent
        for (int n = 0; n < 3000; n++) begin
            step();
            begin
                logic [AW-1:0] a;
                int unsigned mask;
                mask      = ($urandom_range(0, 3) == 0) ? 31 : 7;
                a         = AW'($urandom & mask); rs1 = a;
                a         = AW'($urandom & mask); rs2 = a;
                a         = AW'($urandom & mask); rd = a;
                a         = AW'($urandom & mask); rd_issue = a;
                writedata = $urandom;
                regwrite  = ($urandom_range(0, 1) == 1);
                issue     = ($urandom_range(0, 1) == 1);
                flush     = ($urandom_range(0, 31) == 0);
                if ($urandom_range(0, 199) == 0) begin
                    #1 rst_n = 0; #1 rst_n = 1;
                end
            end
        end
        step(); idle();
        @(posedge clk); @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the pipeline register file: 2 combinational read ports, 1 write-back port, hardwired-zero x0.
- Adds optional write-through bypass, asynchronous clear, and a per-register busy scoreboard (set at issue, cleared at write-back, bulk-cleared on flush).
- Sits between decode/issue and write-back in the pipeline and drives the hazard/stall logic.

Parameters:
- XLEN, 32: register data width in bits.
- NREGS, 32: number of architectural registers. Power of two, ≥2. Address width AW = clog2(NREGS) is a localparam.
- BYPASS, 1: 1 = a same-cycle write-back is forwarded to the read ports; 0 = reads return the stored value only.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- rs1  input  AW  read address, port 1.
- rs2  input  AW  read address, port 2.
- readdata1  output  XLEN  read data, port 1.
- readdata2  output  XLEN  read data, port 2.
- rd  input  AW  write-back address.
- writedata  input  XLEN  write-back data.
- regwrite  input  1  write-back enable.
- rd_issue  input  AW  destination register of the instruction being issued.
- issue  input  1  marks rd_issue busy.
- flush  input  1  clears all busy bits.
- busy1  output  1  effective busy status of rs1.
- busy2  output  1  effective busy status of rs2.
- hazard  output  1  busy1 | busy2.
- busy_count  output  AW+1  number of busy registers.

Behaviour:
- Reset:
  - While rst_n=0, independent of clk: all registers = 0, all busy bits = 0.
  - Outputs follow combinationally: readdata* = 0 (unless bypassing), busy*/hazard = 0, busy_count = 0.
  - Deasserting rst_n in the middle of a sequence leaves everything cleared; no pending write survives.
- Write:
  - At posedge clk, if regwrite=1 and rd≠0: reg[rd] ← writedata.
  - Writes to x0 are discarded.
  - Write latency: the value is visible through storage in the cycle after the edge.
- Read: combinational.
  - readdataN = 0 if rsN=0.
  - Otherwise, if BYPASS=1 and regwrite=1 and rd=rsN: readdataN = writedata (same cycle).
  - Otherwise readdataN = reg[rsN].
- Scoreboard: busy[0] is constant 0. At posedge clk, for each register i≠0, the first matching rule applies:
  1. flush=1 → busy[i] ← 0. Flush overrides issue, but the write-back data write still occurs.
  2. issue=1 and rd_issue=i → busy[i] ← 1. Set wins over a simultaneous write-back clear to the same register, because the new producer is outstanding.
  3. regwrite=1 and rd=i → busy[i] ← 0.
  4. Otherwise hold.
- busyN:
  - busyN = busy[rsN].
  - Exception: 0 when BYPASS=1, regwrite=1, rd=rsN, rsN≠0, since the value is forwarded this cycle.
  - With BYPASS=0, a same-cycle write-back does not mask busy.
- busy_count: popcount of the busy vector, registered state only (no bypass masking). Range 0..NREGS-1.
- Re-issue to an already-busy register: stays busy, count unchanged.
- Write-back to a non-busy register: data written, busy unchanged.

Test Plan:
- Reset clears state: write x1..x5 = 1..5, then pulse rst_n=0 mid-cycle → readdata1/2 = 0 immediately for rs1=1, rs2=5. busy_count = 0.
- x0 hardwired: regwrite=1, rd=0, writedata=0xDEADBEEF, then rs1=0 → readdata1 = 0. issue with rd_issue=0 → busy1 = 0, busy_count = 0.
- Write/read and bypass (BYPASS=1): write x2=2 and x3=3, then rs1=2, rs2=3 → 2, 3. Same cycle as regwrite rd=3, writedata=7 with rs2=3 → readdata2 = 7 before the edge. With regwrite=0 and writedata=6 → x3 stays 7.
- Scoreboard: issue rd_issue=4 → next cycle rs1=4 gives busy1 = 1, hazard = 1, busy_count = 1. In the write-back cycle (regwrite, rd=4, writedata=9): busy1 = 0 and readdata1 = 9 combinationally. After the edge: busy_count = 0.
- Simultaneous set/clear: x5 busy; issue rd_issue=5 and regwrite rd=5 in the same cycle → after the edge busy[5] = 1 and reg[5] holds the new data.
- Flush: issue x1, x2, x3 over 3 cycles (busy_count = 3). Then flush=1 with issue rd_issue=6 and regwrite rd=7, writedata=0x11 → after the edge busy_count = 0 and x7 = 0x11. Repeat the write/read and bypass scenario with BYPASS=0: the same-cycle read returns the old value and busy is not masked.
